// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: data word, RAM handshake state and the
// arbiter FSM encoding, plus the width helper for the starvation counter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DSERV = 2'b01,
        ISERV = 2'b10
    } arb_state_t;

    localparam word_t WORD_ZERO = 32'h0000_0000;

    // A limit of zero still needs a one-bit counter to stay legal.
    function automatic int starve_width(input int unsigned max_val);
        return (max_val < 32'd1) ? 1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive dcache grants taken while icache waits;
// the arbiter forces an icache grant once it reaches MAX.
module arb_starve_ctr
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = starve_width(MAX)
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic         at_max_s;

    assign at_max_s = (count_r == W'(MAX));
    assign count    = count_r;

    // Clear has priority over increment; increment stops at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && !at_max_s) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache with dcache priority and
// icache starvation relief. Define MEMARB_STATS_EN to add completion counters.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
`ifdef MEMARB_STATS_EN
    ,
    output word_t     icount,
    output word_t     dcount
`endif
);

    localparam int unsigned STARVE_W = starve_width(STARVE_MAX);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic                d_req_s;
    logic                ram_access_s;
    logic                d_done_s;
    logic                i_done_s;
    logic                starve_max_s;
    logic                starve_inc_s;
    logic                starve_clr_s;
    logic [STARVE_W-1:0] starve_count_s;

    assign d_req_s      = dREN | dWEN;
    assign ram_access_s = (ramstate == ACCESS);
    // A completion needs the requester still asking, so a dropped request
    // that coincides with ACCESS never produces a wait-low pulse.
    assign d_done_s     = !RST && (state_r == DSERV) && d_req_s && ram_access_s;
    assign i_done_s     = !RST && (state_r == ISERV) && iREN && ram_access_s;

    assign starve_max_s = (starve_count_s == STARVE_W'(STARVE_MAX));
    assign starve_inc_s = d_done_s && iREN;
    assign starve_clr_s = i_done_s || ((state_r == IDLE) && !iREN);

    assign iload = ramload;
    assign dload = ramload;

    arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (STARVE_W)
    ) u_starve (
        .clk   (CLK),
        .rst   (RST),
        .inc   (starve_inc_s),
        .clr   (starve_clr_s),
        .count (starve_count_s)
    );

    // Arbiter state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: dcache wins from IDLE unless icache has starved long enough.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_req_s && !(starve_max_s && iREN)) begin
                    state_nxt_s = DSERV;
                end else if (iREN) begin
                    state_nxt_s = ISERV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DSERV: begin
                if (!d_req_s || ram_access_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DSERV;
                end
            end
            ISERV: begin
                if (!iREN || ram_access_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ISERV;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // RAM-side drive and wait handshakes; everything is quiet while in reset.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = WORD_ZERO;
        ramstore = WORD_ZERO;
        iwait    = 1'b1;
        dwait    = 1'b1;
        if (RST) begin
            ramREN = 1'b0;
        end else begin
            case (state_r)
                DSERV: begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dwait    = !d_done_s;
                end
                ISERV: begin
                    ramREN  = 1'b1;
                    ramWEN  = 1'b0;
                    ramaddr = iaddr;
                    iwait   = !i_done_s;
                end
                default: begin
                    ramREN = 1'b0;
                end
            endcase
        end
    end

`ifdef MEMARB_STATS_EN
    word_t icount_r;
    word_t dcount_r;

    assign icount = icount_r;
    assign dcount = dcount_r;

    // Completion statistics, wrapping naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            icount_r <= WORD_ZERO;
            dcount_r <= WORD_ZERO;
        end else begin
            icount_r <= i_done_s ? (icount_r + 32'd1) : icount_r;
            dcount_r <= d_done_s ? (dcount_r + 32'd1) : dcount_r;
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized
// run against a transaction-level ownership/streak model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned STARVE_MAX = 4;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    word_t     iload, dload, ramaddr, ramstore;
    logic      iwait, dwait, ramREN, ramWEN;
    ramstate_t ramstate;
`ifdef MEMARB_STATS_EN
    word_t     icount, dcount;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEMARB_STATS_EN
        ,
        .icount   (icount),
        .dcount   (dcount)
`endif
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
        ramstate = FREE;
    endtask

    task automatic apply_reset();
        @(posedge CLK); #1;
        idle_inputs();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        word_t ld;
        @(posedge CLK); #1;
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
        iaddr = 32'h1234_5678; daddr = 32'h9abc_def0; dstore = 32'h5555_aaaa;
        ramstate = ACCESS; ld = $urandom(); ramload = ld;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if ({ramREN, ramWEN, ramaddr, ramstore} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
                errors++;
                $display("FAIL reset_bus: got ren=%b wen=%b addr=%h store=%h, required 0 0 0 0",
                         ramREN, ramWEN, ramaddr, ramstore);
            end
            checks++;
            if ({iwait, dwait} !== 2'b11) begin
                errors++;
                $display("FAIL reset_wait: got iwait=%b dwait=%b, required 1 1", iwait, dwait);
            end
            if (c == 0) begin
                @(posedge CLK); #1;
            end
        end
        checks++;
        if ({iload, dload} !== {ld, ld}) begin
            errors++;
            $display("FAIL load_pass: got iload=%h dload=%h, required %h", iload, dload, ld);
        end
        @(posedge CLK); #1;
        idle_inputs();
        @(negedge CLK);
        checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            errors++;
            $display("FAIL idle_out: got ren=%b wen=%b iwait=%b dwait=%b, required 0 0 1 1",
                     ramREN, ramWEN, iwait, dwait);
        end
    endtask

    task automatic test_icache_fetch();
        word_t ld;
        int    low_cnt;
        low_cnt = 0;
        apply_reset();
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLK); #1;
            iREN = (c <= 3); iaddr = 32'h0000_0040;
            ramstate = (c == 3) ? ACCESS : ((c < 3) ? BUSY : FREE);
            ld = $urandom(); ramload = ld;
            @(negedge CLK);
            if (!iwait) low_cnt++;
            if (c == 2 || c == 3) begin
                checks++;
                if ({ramREN, ramWEN, ramaddr} !== {1'b1, 1'b0, 32'h0000_0040}) begin
                    errors++;
                    $display("FAIL ifetch_bus c%0d: got ren=%b wen=%b addr=%h, required 1 0 00000040",
                             c, ramREN, ramWEN, ramaddr);
                end
            end
            if (c == 3) begin
                checks++;
                if (iwait !== 1'b0 || iload !== ld) begin
                    errors++;
                    $display("FAIL ifetch_done: got iwait=%b iload=%h, required 0 %h", iwait, iload, ld);
                end
            end
        end
        checks++;
        if (low_cnt != 1) begin
            errors++;
            $display("FAIL ifetch_pulse: got %0d iwait-low cycles, required 1", low_cnt);
        end
    endtask

    task automatic test_priority();
        word_t da, ia, e_addr;
        logic  e_dw, e_iw, e_ren;
        apply_reset();
        da = $urandom(); ia = $urandom();
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLK); #1;
            dREN = (c <= 2); iREN = (c <= 4); daddr = da; iaddr = ia;
            ramstate = ACCESS; ramload = $urandom();
            case (c)
                2:       begin e_dw = 1'b0; e_iw = 1'b1; e_ren = 1'b1; e_addr = da;    end
                4:       begin e_dw = 1'b1; e_iw = 1'b0; e_ren = 1'b1; e_addr = ia;    end
                default: begin e_dw = 1'b1; e_iw = 1'b1; e_ren = 1'b0; e_addr = 32'h0; end
            endcase
            @(negedge CLK);
            checks++;
            if ({dwait, iwait, ramREN, ramaddr} !== {e_dw, e_iw, e_ren, e_addr}) begin
                errors++;
                $display("FAIL priority c%0d: got dwait=%b iwait=%b ren=%b addr=%h, required %b %b %b %h",
                         c, dwait, iwait, ramREN, ramaddr, e_dw, e_iw, e_ren, e_addr);
            end
        end
    endtask

    task automatic test_starve();
        int events[$];
        int expected[$];
        int cyc;
        apply_reset();
        for (int k = 0; k < int'(STARVE_MAX); k++) expected.push_back(0);
        expected.push_back(1);
        cyc = 0;
        while (events.size() < expected.size() && cyc < 40) begin
            @(posedge CLK); #1;
            dWEN = 1'b1; iREN = 1'b1; daddr = $urandom(); dstore = $urandom();
            iaddr = 32'h0000_0100; ramstate = ACCESS;
            @(negedge CLK);
            if (!dwait) events.push_back(0);
            if (!iwait) events.push_back(1);
            cyc++;
        end
        checks++;
        if (events.size() != expected.size()) begin
            errors++;
            $display("FAIL starve_timeout: got %0d completions in %0d cycles, required %0d",
                     events.size(), cyc, expected.size());
        end else begin
            for (int k = 0; k < expected.size(); k++) begin
                checks++;
                if (events[k] != expected[k]) begin
                    errors++;
                    $display("FAIL starve_order[%0d]: got %s, required %s", k,
                             events[k] ? "icache" : "dcache", expected[k] ? "icache" : "dcache");
                end
            end
        end
        @(posedge CLK); #1;
        iREN = 1'b0; ramstate = BUSY;
        @(negedge CLK);
        checks++;
        if (dut.u_starve.count !== 3'd0) begin
            errors++;
            $display("FAIL starve_clear: got count=%0d, required 0", dut.u_starve.count);
        end
        dWEN = 1'b0;
    endtask

    task automatic test_error_retry();
        apply_reset();
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLK); #1;
            dWEN = 1'b1; daddr = 32'h0000_2000; dstore = 32'hDEAD_BEEF;
            ramstate = (c == 1) ? FREE : ((c == 5) ? ACCESS : ERROR);
            @(negedge CLK);
            if (c >= 2) begin
                checks++;
                if ({dwait, ramWEN, ramstore} !== {(c != 5), 1'b1, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("FAIL error_retry c%0d: got dwait=%b wen=%b store=%h, required %b 1 deadbeef",
                             c, dwait, ramWEN, ramstore, (c != 5));
                end
            end
        end
        @(posedge CLK); #1;
        dWEN = 1'b0; ramstate = FREE;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 1; c <= 4; c++) begin
            @(posedge CLK); #1;
            dREN = 1'b1; daddr = 32'h0000_3000;
            RST = (c == 3);
            ramstate = (c >= 3) ? ACCESS : BUSY;
            @(negedge CLK);
            if (c == 2) begin
                checks++;
                if ({ramREN, dwait} !== 2'b11) begin
                    errors++;
                    $display("FAIL rstmid_busy: got ren=%b dwait=%b, required 1 1", ramREN, dwait);
                end
            end
            if (c >= 3) begin
                checks++;
                if ({ramREN, ramWEN, dwait, iwait} !== 4'b0011) begin
                    errors++;
                    $display("FAIL rstmid_c%0d: got ren=%b wen=%b dwait=%b iwait=%b, required 0 0 1 1",
                             c, ramREN, ramWEN, dwait, iwait);
                end
            end
        end
        @(posedge CLK); #1;
        idle_inputs();
    endtask

`ifdef MEMARB_STATS_EN
    task automatic run_txn(input logic is_d);
        int  cyc;
        logic done;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 8) begin
            @(posedge CLK); #1;
            dREN = is_d; iREN = !is_d; daddr = $urandom(); iaddr = $urandom();
            ramstate = ACCESS;
            @(negedge CLK);
            done = is_d ? !dwait : !iwait;
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL stats_txn: got no completion in %0d cycles, required one", cyc);
        end
        @(posedge CLK); #1;
        dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    endtask

    task automatic test_stats();
        apply_reset();
        @(negedge CLK);
        checks++;
        if ({icount, dcount} !== 64'h0) begin
            errors++;
            $display("FAIL stats_reset: got icount=%0d dcount=%0d, required 0 0", icount, dcount);
        end
        for (int k = 0; k < 5; k++) run_txn(k < 3);
        @(negedge CLK);
        checks++;
        if (dcount !== 32'd3 || icount !== 32'd2) begin
            errors++;
            $display("FAIL stats_count: got dcount=%0d icount=%0d, required 3 2", dcount, icount);
        end
    endtask
`endif

    // Model: who owns the RAM (0 none, 1 dcache, 2 icache) and how many
    // dcache completions in a row icache has watched.
    task automatic test_random();
        int    owner, streak, icnt, dcnt;
        logic  i_pend, d_pend, d_rd, d_wr, d_done, i_done, dreq;
        logic  e_ren, e_wen, e_iw, e_dw;
        word_t e_addr, e_store, ld;
        int    r;
        owner = 0; streak = 0; icnt = 0; dcnt = 0;
        i_pend = 1'b0; d_pend = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge CLK); #1;
            if (!i_pend && $urandom_range(0, 99) < 35) begin
                i_pend = 1'b1; iaddr = $urandom();
            end else if (i_pend && $urandom_range(0, 99) < 4) begin
                i_pend = 1'b0;
            end
            if (!d_pend && $urandom_range(0, 99) < 45) begin
                d_pend = 1'b1; daddr = $urandom(); dstore = $urandom();
                r = $urandom_range(0, 9);
                d_rd = (r < 5) || (r == 9); d_wr = (r >= 5);
            end else if (d_pend && $urandom_range(0, 99) < 4) begin
                d_pend = 1'b0;
            end
            iREN = i_pend; dREN = d_pend & d_rd; dWEN = d_pend & d_wr;
            RST = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 99);
            ramstate = (r < 40) ? ACCESS : ((r < 70) ? BUSY : ((r < 85) ? FREE : ERROR));
            ld = $urandom(); ramload = ld;

            dreq = dREN | dWEN;
            d_done = !RST && owner == 1 && dreq && ramstate == ACCESS;
            i_done = !RST && owner == 2 && iREN && ramstate == ACCESS;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0; e_iw = 1'b1; e_dw = 1'b1;
            if (!RST && owner == 1) begin
                e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore; e_dw = !d_done;
            end else if (!RST && owner == 2) begin
                e_ren = 1'b1; e_addr = iaddr; e_iw = !i_done;
            end

            @(negedge CLK);
            checks++;
            if ({ramREN, ramWEN, ramaddr, ramstore} !== {e_ren, e_wen, e_addr, e_store}) begin
                errors++;
                $display("FAIL rand_bus cyc%0d: got ren=%b wen=%b addr=%h store=%h, required %b %b %h %h",
                         cyc, ramREN, ramWEN, ramaddr, ramstore, e_ren, e_wen, e_addr, e_store);
            end
            checks++;
            if ({iwait, dwait} !== {e_iw, e_dw}) begin
                errors++;
                $display("FAIL rand_wait cyc%0d: got iwait=%b dwait=%b, required %b %b",
                         cyc, iwait, dwait, e_iw, e_dw);
            end
            checks++;
            if ({iload, dload} !== {ld, ld}) begin
                errors++;
                $display("FAIL rand_load cyc%0d: got iload=%h dload=%h, required %h", cyc, iload, dload, ld);
            end

            if (RST) begin
                owner = 0; streak = 0; icnt = 0; dcnt = 0;
            end else if (owner == 0) begin
                if (!iREN) streak = 0;
                if (dreq && !(streak == int'(STARVE_MAX) && iREN)) owner = 1;
                else if (iREN) owner = 2;
            end else if (owner == 1) begin
                if (d_done) begin
                    dcnt++;
                    if (iREN) streak = (streak < int'(STARVE_MAX)) ? streak + 1 : int'(STARVE_MAX);
                end
                if (!dreq || ramstate == ACCESS) owner = 0;
            end else begin
                if (i_done) begin
                    icnt++; streak = 0;
                end
                if (!iREN || ramstate == ACCESS) owner = 0;
            end
            if (d_done) d_pend = 1'b0;
            if (i_done) i_pend = 1'b0;
        end
`ifdef MEMARB_STATS_EN
        checks++;
        if (icount !== word_t'(icnt) || dcount !== word_t'(dcnt)) begin
            errors++;
            $display("FAIL rand_stats: got icount=%0d dcount=%0d, required %0d %0d", icount, dcount, icnt, dcnt);
        end
`endif
        @(posedge CLK); #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        test_reset();
        test_icache_fetch();
        test_priority();
        test_starve();
        test_error_retry();
        test_reset_mid();
`ifdef MEMARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
